// File: rtl/sr_input_conditioner.sv
// sr_input_conditioner
//   Front-end for the SR latch stage. Each raw request input (set_in,
//   reset_in) is synchronised into clk, then debounced by a small FSM.
//   The debounced levels drive registered, mutually exclusive S/R outputs,
//   one-cycle rise pulses, and a conflict flag. The outputs never show S=R=1.
//
// Ports
//   clk      : system clock, every register updates on its rising edge
//   reset    : synchronous, active-high reset
//   set_in   : raw asynchronous set request
//   reset_in : raw asynchronous reset request
//   S, R     : clean, mutually exclusive set/reset levels to the latch
//   s_rise   : one-cycle pulse when S goes 0->1
//   r_rise   : one-cycle pulse when R goes 0->1
//   conflict : both debounced requests are active (S and R are held low)
//
// Debounce state is kept in st_q[]/cnt_q[] (index 0 = set, 1 = reset) so
// checkers can bind to it by name.
module sr_input_conditioner #(
    parameter  int SYNC_STAGES     = 2,
    parameter  int DEBOUNCE_CYCLES = 4,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic set_in,
    input  logic reset_in,
    output logic S,
    output logic R,
    output logic s_rise,
    output logic r_rise,
    output logic conflict
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } db_state_e;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]             raw;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [SYNC_STAGES-1:0] sync_d [2];
    logic [1:0]             sync_lvl;
    db_state_e              st_q   [2];
    db_state_e              st_d   [2];
    logic [CNT_W-1:0]       cnt_q  [2];
    logic [CNT_W-1:0]       cnt_d  [2];
    logic [1:0]             db;

    logic s_q, r_q, s_rise_q, r_rise_q, conflict_q;
    logic s_d, r_d, s_rise_d, r_rise_d, conflict_d;

    assign raw = {reset_in, set_in};

    // Synchronisers: bit 0 is the first stage, the MSB is the synchronised level.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            sync_d[c]   = {sync_q[c][SYNC_STAGES-2:0], raw[c]};
            sync_lvl[c] = sync_q[c][SYNC_STAGES-1];
        end
    end

    // Debounce FSMs. A level is accepted once it has been seen on
    // DEBOUNCE_CYCLES consecutive synchronised cycles; any opposite sample
    // while checking returns to the previous stable state.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            st_d[c]  = st_q[c];
            cnt_d[c] = cnt_q[c];
            case (st_q[c])
                STABLE_LO: begin
                    if (sync_lvl[c]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            st_d[c]  = STABLE_HI;
                            cnt_d[c] = '0;
                        end else begin
                            st_d[c]  = CHK_HI;
                            cnt_d[c] = CNT_ONE;
                        end
                    end
                end
                CHK_HI: begin
                    if (!sync_lvl[c]) begin
                        st_d[c]  = STABLE_LO;
                        cnt_d[c] = '0;
                    end else if (cnt_q[c] == CNT_LAST) begin
                        st_d[c]  = STABLE_HI;
                        cnt_d[c] = '0;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CNT_ONE;
                    end
                end
                STABLE_HI: begin
                    if (!sync_lvl[c]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            st_d[c]  = STABLE_LO;
                            cnt_d[c] = '0;
                        end else begin
                            st_d[c]  = CHK_LO;
                            cnt_d[c] = CNT_ONE;
                        end
                    end
                end
                CHK_LO: begin
                    if (sync_lvl[c]) begin
                        st_d[c]  = STABLE_HI;
                        cnt_d[c] = '0;
                    end else if (cnt_q[c] == CNT_LAST) begin
                        st_d[c]  = STABLE_LO;
                        cnt_d[c] = '0;
                    end else begin
                        cnt_d[c] = cnt_q[c] + CNT_ONE;
                    end
                end
                default: begin
                    st_d[c]  = STABLE_LO;
                    cnt_d[c] = '0;
                end
            endcase
            // The debounced level stays high while a falling edge is being checked.
            db[c] = (st_q[c] == STABLE_HI) || (st_q[c] == CHK_LO);
        end
    end

    // Output stage. S and R come from exclusive terms, so they can never
    // both be high. A rise pulse needs the exclusive term, so no pulse can
    // fire while both requests are active.
    always_comb begin
        s_d        = db[0] & ~db[1];
        r_d        = db[1] & ~db[0];
        conflict_d = db[0] & db[1];
        s_rise_d   = s_d & ~s_q;
        r_rise_d   = r_d & ~r_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                sync_q[c] <= '0;
                st_q[c]   <= STABLE_LO;
                cnt_q[c]  <= '0;
            end
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            s_rise_q   <= 1'b0;
            r_rise_q   <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                sync_q[c] <= sync_d[c];
                st_q[c]   <= st_d[c];
                cnt_q[c]  <= cnt_d[c];
            end
            s_q        <= s_d;
            r_q        <= r_d;
            s_rise_q   <= s_rise_d;
            r_rise_q   <= r_rise_d;
            conflict_q <= conflict_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign s_rise   = s_rise_q;
    assign r_rise   = r_rise_q;
    assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Bench for sr_input_conditioner with default parameters.
// A reference model runs at every rising edge and pushes the expected
// {S, R, s_rise, r_rise, conflict}. A monitor on the falling edge pops one
// expected value and compares it with the DUT. Directed sequences also
// measure latencies and pulse counts against fixed expected numbers.
module tb_sr_input_conditioner;

    localparam int SYNC = 2;
    localparam int DB   = 4;

    logic clk;
    logic reset;
    logic set_in;
    logic reset_in;
    logic S, R, s_rise, r_rise, conflict;

    int n_assert = 0;
    int n_fail   = 0;

    sr_input_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .set_in   (set_in),
        .reset_in (reset_in),
        .S        (S),
        .R        (R),
        .s_rise   (s_rise),
        .r_rise   (r_rise),
        .conflict (conflict)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Behaviour: each channel sees its raw input SYNC edges late. Its
    // debounced level flips after DB consecutive samples that differ from
    // the current level. The outputs are registered from those levels one
    // edge later.
    logic [4:0] exp_q[$];
    logic       hist_s[$];
    logic       hist_r[$];
    logic       m_valid = 1'b0;
    logic       m_db_s, m_db_r, m_S, m_R;
    int         m_run_s, m_run_r;
    logic       m_ns, m_nr, m_seen_s, m_seen_r;

    always @(posedge clk) begin
        if (reset) begin
            hist_s.delete();
            hist_r.delete();
            for (int i = 0; i < SYNC; i++) begin
                hist_s.push_back(1'b0);
                hist_r.push_back(1'b0);
            end
            m_db_s  = 1'b0;
            m_db_r  = 1'b0;
            m_run_s = 0;
            m_run_r = 0;
            m_S     = 1'b0;
            m_R     = 1'b0;
            m_valid = 1'b1;
            exp_q.push_back(5'b0);
        end else if (m_valid) begin
            m_ns = m_db_s && !m_db_r;
            m_nr = m_db_r && !m_db_s;
            exp_q.push_back({m_ns, m_nr, m_ns && !m_S, m_nr && !m_R, m_db_s && m_db_r});
            m_S = m_ns;
            m_R = m_nr;
            m_seen_s = hist_s[SYNC-1];
            m_seen_r = hist_r[SYNC-1];
            hist_s.push_front(set_in);
            hist_r.push_front(reset_in);
            void'(hist_s.pop_back());
            void'(hist_r.pop_back());
            if (m_seen_s != m_db_s) begin
                m_run_s++;
                if (m_run_s == DB) begin
                    m_db_s  = m_seen_s;
                    m_run_s = 0;
                end
            end else begin
                m_run_s = 0;
            end
            if (m_seen_r != m_db_r) begin
                m_run_r++;
                if (m_run_r == DB) begin
                    m_db_r  = m_seen_r;
                    m_run_r = 0;
                end
            end else begin
                m_run_r = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic       prev_S = 1'b0;
    logic [4:0] got_v, exp_v;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            got_v = {S, R, s_rise, r_rise, conflict};
            exp_v = exp_q.pop_front();
            n_assert++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t: got {S,R,s_rise,r_rise,conflict}=%b expected %b",
                         $time, got_v, exp_v);
            end
            n_assert++;
            if (S === 1'b1 && R === 1'b1) begin
                n_fail++;
                $display("FAIL s_and_r t=%0t: got S=%b R=%b expected not both 1", $time, S, R);
            end
            if (s_rise === 1'b1) begin
                n_assert++;
                if (!(S === 1'b1 && prev_S === 1'b0)) begin
                    n_fail++;
                    $display("FAIL s_rise_edge t=%0t: got S=%b prev_S=%b expected S=1 prev_S=0",
                             $time, S, prev_S);
                end
            end
            prev_S = S;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input int got, input int exp);
        n_assert++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Hold reset for n edges; returns just after the last reset edge.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // Apply one pattern bit per cycle. Bit i is first sampled at edge i+1.
    // Records the edge numbers of the first s_rise, r_rise, conflict and S fall,
    // plus the pulse counts and the number of cycles S was high.
    task automatic play(input int len, input logic [63:0] sp, input logic [63:0] rp,
                        output int s_at, output int r_at, output int c_at,
                        output int s_fall, output int n_sr, output int n_rr,
                        output int n_sh);
        logic s_was;
        s_at = 0; r_at = 0; c_at = 0; s_fall = 0; n_sr = 0; n_rr = 0; n_sh = 0;
        s_was = S;
        for (int i = 0; i < len; i++) begin
            set_in   = sp[i];
            reset_in = rp[i];
            @(posedge clk);
            #1;
            if (s_rise && s_at == 0)   s_at = i + 1;
            if (r_rise && r_at == 0)   r_at = i + 1;
            if (conflict && c_at == 0) c_at = i + 1;
            if (s_was && !S && s_fall == 0) s_fall = i + 1;
            if (s_rise) n_sr++;
            if (r_rise) n_rr++;
            if (S)      n_sh++;
            s_was = S;
        end
    endtask

    // ---------------- test sequence ----------------
    int s_at, r_at, c_at, s_fall, n_sr, n_rr, n_sh;
    logic [63:0] ones;
    logic [63:0] bounce;

    initial begin
        ones     = '1;
        bounce   = 64'hFFFF_FFFF_FFFF_FFED;  // 1,0,1,1,0,1,1,1,1 then held high
        reset    = 1'b1;
        set_in   = 1'b0;
        reset_in = 1'b0;

        // Reset for two cycles, then set_in held high.
        do_reset(2);
        chk("reset_outputs", {S, R, s_rise, r_rise, conflict}, 0);
        play(12, ones, 64'h0, s_at, r_at, c_at, s_fall, n_sr, n_rr, n_sh);
        chk("set_latency", s_at, 7);
        chk("set_rise_once", n_sr, 1);
        chk("set_high_cycles", n_sh, 6);
        chk("set_no_r_rise", n_rr, 0);
        chk("set_no_conflict", c_at, 0);

        // Both requests active, then set_in released.
        play(12, ones, ones, s_at, r_at, c_at, s_fall, n_sr, n_rr, n_sh);
        chk("conflict_latency", c_at, 7);
        chk("conflict_s_fall", s_fall, 7);
        chk("conflict_no_r_rise", n_rr, 0);
        chk("conflict_no_s_rise", n_sr, 0);
        play(12, 64'h0, ones, s_at, r_at, c_at, s_fall, n_sr, n_rr, n_sh);
        chk("release_r_latency", r_at, 7);
        chk("release_r_rise_once", n_rr, 1);
        chk("release_conflict_clear", conflict, 0);
        chk("release_r_level", R, 1);

        // Short pulses: 3 cycles rejected, 4 cycles accepted.
        do_reset(1);
        play(20, 64'h7, 64'h0, s_at, r_at, c_at, s_fall, n_sr, n_rr, n_sh);
        chk("glitch3_s_high", n_sh, 0);
        chk("glitch3_s_rise", n_sr, 0);
        chk("glitch3_conflict", c_at, 0);
        play(20, 64'hF, 64'h0, s_at, r_at, c_at, s_fall, n_sr, n_rr, n_sh);
        chk("pulse4_rise", s_at, 7);
        chk("pulse4_fall", s_fall, 11);
        chk("pulse4_rise_once", n_sr, 1);

        // Bouncing reset_in: only the final run of at least 4 counts.
        do_reset(1);
        play(20, 64'h0, bounce, s_at, r_at, c_at, s_fall, n_sr, n_rr, n_sh);
        chk("bounce_r_latency", r_at, 12);
        chk("bounce_r_rise_once", n_rr, 1);

        // Reset in the middle of the set_in debounce window.
        do_reset(1);
        play(4, ones, 64'h0, s_at, r_at, c_at, s_fall, n_sr, n_rr, n_sh);
        do_reset(1);
        chk("mid_reset_outputs", {S, R, s_rise, r_rise, conflict}, 0);
        play(12, ones, 64'h0, s_at, r_at, c_at, s_fall, n_sr, n_rr, n_sh);
        chk("mid_reset_requalify", s_at, 7);
        chk("mid_reset_rise_once", n_sr, 1);

        // Reset while S is high, with set_in still held.
        do_reset(1);
        chk("high_reset_outputs", {S, R, s_rise, r_rise, conflict}, 0);
        play(12, ones, 64'h0, s_at, r_at, c_at, s_fall, n_sr, n_rr, n_sh);
        chk("high_reset_requalify", s_at, 7);

        // Random toggling. Toggles are rare enough that many holds pass debounce.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 5) == 0) set_in   = ~set_in;
            if ($urandom_range(0, 5) == 0) reset_in = ~reset_in;
            @(posedge clk);
            #1;
        end

        set_in   = 1'b0;
        reset_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
